// File: rtl/c3lib_nandn_pipe_svt.sv
// c3lib_nandn_pipe_svt: NUM_IN-way bitwise NAND with valid/ready register pipeline.
// Define C3LIB_NANDN_STICKY_EN to build the out_sticky all-ones detect flops.
module c3lib_nandn_pipe_svt #(
  parameter int NUM_IN      = 2,
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_vld,
  output logic                    in_rdy,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  input  logic                    sticky_clr,
  output logic [WIDTH-1:0]        out_sticky
);
  logic [WIDTH-1:0] and_red;
  always_comb begin
    and_red = '1;
    for (int i = 0; i < NUM_IN; i++) and_red = and_red & in_data[i*WIDTH +: WIDTH];
  end
  generate
    if (PIPE_STAGES == 0) begin : g_comb
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign out_data = ~and_red;
      assign out_vld  = in_vld;
      assign in_rdy   = out_rdy;
    end else begin : g_pipe
      logic [WIDTH-1:0]       sd [PIPE_STAGES];
      logic [PIPE_STAGES-1:0] sv;
      logic                   adv;
      assign adv      = out_rdy | ~sv[PIPE_STAGES-1];
      assign in_rdy   = adv;
      assign out_data = sd[PIPE_STAGES-1];
      assign out_vld  = sv[PIPE_STAGES-1];
      // data only moves with a valid beat so out_data holds across bubbles
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          sv <= '0;
          for (int s = 0; s < PIPE_STAGES; s++) sd[s] <= '1;
        end else if (adv) begin
          sv[0] <= in_vld;
          if (in_vld) sd[0] <= ~and_red;
          for (int s = 1; s < PIPE_STAGES; s++) begin
            sv[s] <= sv[s-1];
            if (sv[s-1]) sd[s] <= sd[s-1];
          end
        end
    end
  endgenerate
`ifdef C3LIB_NANDN_STICKY_EN
  // set term is OR-ed last so a same-cycle set beats the clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_sticky <= '0;
    else out_sticky <= (out_sticky & ~{WIDTH{sticky_clr}}) | ({WIDTH{out_vld & out_rdy}} & ~out_data);
`else
  logic unused_sticky;
  assign unused_sticky = sticky_clr;
  assign out_sticky = '0;
`endif
endmodule

// File: tb/tb_c3lib_nandn_pipe_svt.sv
// tb_c3lib_nandn_pipe_svt: directed checks of c3lib_nandn_pipe_svt across four configurations.
module tb_c3lib_nandn_pipe_svt;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  int tx, rx;
`ifdef C3LIB_NANDN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic [1:0]  a_d;
  logic        a_iv, a_ir, a_od, a_ov, a_or, a_st;
  logic [31:0] b_d;
  logic        b_iv, b_ir, b_ov, b_or;
  logic [7:0]  b_od, b_st;
  logic [15:0] c_d;
  logic        c_iv, c_ir, c_ov, c_or;
  logic [7:0]  c_od, c_st;
  logic [7:0]  d_d;
  logic        d_iv, d_ir, d_ov, d_or, d_clr;
  logic [3:0]  d_od, d_st;
  c3lib_nandn_pipe_svt #(.NUM_IN(2), .WIDTH(1), .PIPE_STAGES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(a_d), .in_vld(a_iv), .in_rdy(a_ir),
    .out_data(a_od), .out_vld(a_ov), .out_rdy(a_or), .sticky_clr(1'b0), .out_sticky(a_st));
  c3lib_nandn_pipe_svt #(.NUM_IN(4), .WIDTH(8), .PIPE_STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(b_d), .in_vld(b_iv), .in_rdy(b_ir),
    .out_data(b_od), .out_vld(b_ov), .out_rdy(b_or), .sticky_clr(1'b0), .out_sticky(b_st));
  c3lib_nandn_pipe_svt #(.NUM_IN(2), .WIDTH(8), .PIPE_STAGES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(c_d), .in_vld(c_iv), .in_rdy(c_ir),
    .out_data(c_od), .out_vld(c_ov), .out_rdy(c_or), .sticky_clr(1'b0), .out_sticky(c_st));
  c3lib_nandn_pipe_svt #(.NUM_IN(2), .WIDTH(4), .PIPE_STAGES(1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(d_d), .in_vld(d_iv), .in_rdy(d_ir),
    .out_data(d_od), .out_vld(d_ov), .out_rdy(d_or), .sticky_clr(d_clr), .out_sticky(d_st));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    a_d = '0; a_iv = 0; a_or = 1;
    b_d = '0; b_iv = 0; b_or = 1;
    c_d = '0; c_iv = 0; c_or = 1;
    d_d = '0; d_iv = 0; d_or = 1; d_clr = 0;
    rst_n = 0;
    #1;
    chk("rst_vld", b_ov, 0);
    chk("rst_data", b_od, 8'hFF);
    chk("rst_in_rdy", b_ir, 1);
    chk("rst_data3", c_od, 8'hFF);
    chk("rst_sticky", d_st, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      a_d = i[1:0]; a_iv = 1; a_or = 1;
      #1;
      chk("nand2_data", a_od, (i == 3) ? 0 : 1);
      chk("nand2_vld", a_ov, 1);
    end
    a_or = 0;
    #1 chk("nand2_rdy_lo", a_ir, 0);
    a_or = 1;
    #1 chk("nand2_rdy_hi", a_ir, 1);
    chk("nand2_sticky", a_st, 0);
    @(posedge clk); #1;
    b_d = {8'hF0, 8'h0F, 8'hFF, 8'hFF}; b_iv = 1;
    #1 chk("p2_accept_rdy", b_ir, 1);
    @(posedge clk); #1 b_iv = 0;
    chk("p2_lat1_vld", b_ov, 0);
    @(posedge clk); #1;
    chk("p2_lat2_vld", b_ov, 1);
    chk("p2_lat2_data", b_od, 8'hFF);
    b_d = '1; b_iv = 1;
    @(posedge clk); #1 b_iv = 0;
    @(posedge clk); #1;
    chk("p2_ones_vld", b_ov, 1);
    chk("p2_ones_data", b_od, 8'h00);
    @(posedge clk); #1;
    chk("p2_idle_vld", b_ov, 0);
    chk("p2_idle_hold", b_od, 8'h00);
    for (int k = 0; k < 6; k++) begin
      b_iv = (k == 0 || k == 2);
      b_d = (k < 2) ? {24'hFFFFFF, 8'h3C} : {16'hFFFF, 8'hA5, 8'hFF};
      if (k >= 2) begin
        chk("bub_vld", b_ov, (k == 2 || k == 4));
        chk("bub_data", b_od, (k < 4) ? 8'hC3 : 8'h5A);
      end
      @(posedge clk); #1;
    end
    b_iv = 0;
    tx = 0; rx = 0;
    for (int c = 0; c < 30; c++) begin
      c_or = !(c >= 6 && c < 10);
      c_iv = (tx < 8);
      c_d = {8'hFF, 8'h10 + tx[7:0]};
      #1;
      if (!c_or && c_ov) begin
        chk("bp_in_rdy", c_ir, 0);
        chk("bp_hold_data", c_od, 8'hEF - rx[7:0]);
      end
      if (c_ov && c_or) begin
        chk("bp_data", c_od, 8'hEF - rx[7:0]);
        rx++;
      end
      if (c_iv && c_ir) tx++;
      @(posedge clk); #1;
    end
    c_iv = 0; c_or = 1;
    chk("bp_rx_count", rx, 8);
    chk("bp_tx_count", tx, 8);
    for (int j = 0; j < 3; j++) begin
      c_iv = 1; c_d = {8'hFF, 8'h20 + j[7:0]};
      @(posedge clk); #1;
    end
    c_iv = 0;
    chk("rs_pre_vld", c_ov, 1);
    chk("rs_pre_data", c_od, 8'hDF);
    rst_n = 0;
    #1;
    chk("rs_vld", c_ov, 0);
    chk("rs_data", c_od, 8'hFF);
    chk("rs_in_rdy", c_ir, 1);
    @(posedge clk); #1 rst_n = 1;
    c_iv = 1; c_d = {8'hFF, 8'h77};
    @(posedge clk); #1 c_iv = 0;
    chk("rs_after1_vld", c_ov, 0);
    @(posedge clk); #1;
    chk("rs_after2_vld", c_ov, 0);
    @(posedge clk); #1;
    chk("rs_after3_vld", c_ov, 1);
    chk("rs_after3_data", c_od, 8'h88);
    d_or = 1; d_iv = 1; d_d = {4'hF, 4'hA};
    @(posedge clk); #1 d_iv = 0;
    chk("st_beat1_vld", d_ov, 1);
    chk("st_beat1_data", d_od, 4'h5);
    chk("st_pre", d_st, 0);
    @(posedge clk); #1;
    chk("st_set", d_st, STICKY ? 4'hA : 4'h0);
    d_iv = 1; d_d = {4'hF, 4'h1};
    @(posedge clk); #1 d_iv = 0; d_clr = 1;
    chk("st_beat2_data", d_od, 4'hE);
    @(posedge clk); #1 d_clr = 0;
    chk("st_set_wins", d_st, STICKY ? 4'h1 : 4'h0);
    @(posedge clk); #1;
    chk("st_hold", d_st, STICKY ? 4'h1 : 4'h0);
    d_clr = 1;
    @(posedge clk); #1 d_clr = 0;
    chk("st_clear", d_st, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
